regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file with write-through bypass and per-register busy

---
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Read, writeback and claim buses of the multi-port register file.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_READ*AW-1:0]         rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           wr_en;
  logic [AW-1:0]                  wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           claim_en;
  logic [AW-1:0]                  claim_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass, busy scoreboard
// and a post-reset clear sweep (one register per cycle).
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic         init_done,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  wr_q, claim_q;
  logic                  mem_we;
  logic [AW-1:0]         mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  // Operations are gated on init_done so nothing reaches the array before the sweep ends.
  assign wr_q    = init_done & bus.wr_en &
                   ~((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign claim_q = init_done & bus.claim_en &
                   ~((ZERO_REG != 0) && (bus.claim_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wa    = cnt;
    mem_wd    = '0;
    case (state)
      INIT: begin
        mem_we = ~reset;
        if (cnt == AW'(NUM_REGS - 1)) state_nxt = RUN;
      end
      RUN: begin
        mem_we = wr_q & ~reset;
        mem_wa = bus.wr_addr;
        mem_wd = bus.wr_data;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      init_done <= 1'b0;
      busy      <= '0;
    end else begin
      if (state == INIT) cnt <= cnt + 1'b1;
      init_done <= (state == RUN);
      // Claim is applied after release so a same-address claim leaves the register busy.
      if (wr_q)    busy[bus.wr_addr]    <= 1'b0;
      if (claim_q) busy[bus.claim_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin : rd_port
      logic [AW-1:0] ra;
      ra = bus.rd_addr[i*AW +: AW];
      if (init_done && !((ZERO_REG != 0) && (ra == '0))) begin
        if ((BYPASS != 0) && wr_q && (ra == bus.wr_addr)) begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
          bus.rd_busy[i]                          = 1'b0;
        end else begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
          bus.rd_busy[i]                          = busy[ra];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic reset;
  logic init_done;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model [NR];
  logic        mbusy [NR];
  logic        c_wen, c_cen;
  logic [4:0]  c_waddr, c_caddr, c_ra0, c_ra1;
  logic [31:0] c_wdata;

  regfile_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NP)) bus ();

  regfile_mp #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NP), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (c_wen && c_waddr != 5'd0 && a == c_waddr) return c_wdata;
    return model[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (c_wen && c_waddr != 5'd0 && a == c_waddr) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NR; k++) begin
      model[k] = '0;
      mbusy[k] = 1'b0;
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic cen, input logic [4:0] caddr,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    c_wen = wen; c_waddr = waddr; c_wdata = wdata;
    c_cen = cen; c_caddr = caddr; c_ra0 = ra0; c_ra1 = ra1;
    bus.wr_en = wen; bus.wr_addr = waddr; bus.wr_data = wdata;
    bus.claim_en = cen; bus.claim_addr = caddr;
    bus.rd_addr = {ra1, ra0};
    #1;
  endtask

  task automatic check_ports(input string tag);
    check({tag, ".d0"}, bus.rd_data[31:0],  exp_data(c_ra0));
    check({tag, ".d1"}, bus.rd_data[63:32], exp_data(c_ra1));
    check({tag, ".b0"}, {31'b0, bus.rd_busy[0]}, {31'b0, exp_busy(c_ra0)});
    check({tag, ".b1"}, {31'b0, bus.rd_busy[1]}, {31'b0, exp_busy(c_ra1)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (c_wen && c_waddr != 5'd0) begin
      model[c_waddr] = c_wdata;
      mbusy[c_waddr] = 1'b0;
    end
    if (c_cen && c_caddr != 5'd0) mbusy[c_caddr] = 1'b1;
  endtask

  // Counts edges after reset release; init_done must first be seen after edge 33.
  task automatic sweep_check(input string tag);
    for (int k = 1; k <= NR + 1; k++) begin
      @(posedge clk); #1;
      check(tag, {31'b0, init_done}, {31'b0, (k >= NR + 1)});
      if (k < NR + 1) check({tag, ".rd"}, bus.rd_data[31:0], 32'h0);
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.claim_en = 1'b0; bus.claim_addr = '0; bus.rd_addr = '0;
    c_wen = 1'b0; c_cen = 1'b0; c_waddr = '0; c_caddr = '0; c_wdata = '0;
    c_ra0 = '0; c_ra1 = '0;
    model_clear();

    @(posedge clk); #1;
    check("rst.init_done", {31'b0, init_done}, 32'h0);
    check("rst.busy", {30'b0, bus.rd_busy}, 32'h0);
    check("rst.data", bus.rd_data[31:0], 32'h0);

    // Release and drive ignored traffic during the sweep
    @(negedge clk);
    reset = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hCAFE_F00D;
    bus.claim_en = 1'b1; bus.claim_addr = 5'd6; bus.rd_addr = {5'd6, 5'd2};
    sweep_check("sweep1");

    for (int k = 0; k < NR; k += 2) begin
      drive(1'b0, '0, '0, 1'b0, '0, 5'(k), 5'(k + 1));
      check_ports("allzero");
      check("allzero.lit", bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
      tick();
    end

    // Write-through bypass, then stored value
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd1);
    check_ports("byp");
    check("byp.lit", bus.rd_data[31:0], 32'hDEADBEEF);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    check_ports("stored");
    check("stored.lit", bus.rd_data[63:32], 32'hDEADBEEF);
    tick();

    // Claim then writeback releases busy
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    check_ports("claim7.pre");
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
    check_ports("claim7.busy");
    check("claim7.busy.lit", {31'b0, bus.rd_busy[0]}, 32'h1);
    tick();
    drive(1'b1, 5'd7, 32'h1234, 1'b0, '0, 5'd7, 5'd5);
    check_ports("wb7");
    check("wb7.lit", {31'b0, bus.rd_busy[0]}, 32'h0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
    check_ports("wb7.after");
    check("wb7.after.lit", {bus.rd_data[31:1], bus.rd_busy[0]}, {31'h1234 >> 1, 1'b0});
    tick();

    // Same-address write and claim: claim wins
    drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd9);
    check_ports("wc9");
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    check_ports("wc9.after");
    check("wc9.lit.d", bus.rd_data[31:0], 32'h55);
    check("wc9.lit.b", {31'b0, bus.rd_busy[1]}, 32'h1);
    tick();

    // Register zero is hardwired
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    check_ports("x0.same");
    check("x0.same.lit", bus.rd_data[31:0], 32'h0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd9);
    check_ports("x0.after");
    check("x0.after.lit", {31'b0, bus.rd_busy[0]}, 32'h0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 2) == 0), rnd_addr(), rnd_addr(), rnd_addr());
      check_ports("rand");
      tick();
    end

    // Mid-sweep reset restarts the sweep and clears state
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 5'd3, 5'd4);
    tick();
    @(negedge clk);
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.claim_en = 1'b0; bus.rd_addr = {5'd4, 5'd3};
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst2.init_done", {31'b0, init_done}, 32'h0);
    check("rst2.x3", bus.rd_data[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    sweep_check("sweep2");
    drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd4);
    check_ports("rst2.after");
    check("rst2.after.lit", {bus.rd_data[31:0] | bus.rd_data[63:32]} | {30'b0, bus.rd_busy}, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
